// File: rtl/mem_port_pkg.sv
// Width helpers shared by the memory-side blocks (skid buffer, read port, FIFO).
// Widths come from the depth parameters, so every block sizes counters the same way.
package mem_port_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to index depth entries; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_interface.sv
// Pipeline link between blocks: producer drives valid/data, consumer drives ack.
// A transfer happens in any cycle where valid && ack are both high. ack may be high without
// valid. A producer holds valid and data stable until the transfer happens.
interface data_interface #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport producer (output valid, output data, input ack);
    modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head shows the oldest entry while count != 0.
// The FIFO has no flow control of its own; callers must never push when full or pop when empty.
module sync_fifo_fwft import mem_port_pkg::*; #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 4,
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count
);
    localparam int            PW      = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (count == DEPTH_C)));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(pop && (count == '0)));

endmodule

// File: rtl/mem_read_port.sv
// Credit-based read port: issues RAM reads from an address stream and returns the words
// in order through a result FIFO. A read is issued only when a FIFO slot is reserved for it.
module mem_read_port import mem_port_pkg::*; #(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    data_interface.consumer       in,
    data_interface.producer       out,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_read_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);
    localparam int            CW      = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("mem_read_port: DEPTH must be at least 1");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("mem_read_port: READ_LATENCY must be at least 1");
    end

    logic [CW-1:0]           used;
    logic [CW-1:0]           fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [READ_LATENCY-1:0] pend;
    logic                    in_fire;
    logic                    out_fire;
    logic                    capture;

    assign out.valid = reset_n && (fifo_count != '0);
    assign out.data  = out.valid ? fifo_head : '0;
    assign out_fire  = out.valid && out.ack;

    // A pop in this cycle frees its slot in time for a read issued in the same cycle.
    assign in.ack          = reset_n && ((used < DEPTH_C) || out_fire);
    assign in_fire         = in.valid && in.ack;
    assign ram_read_enable = in_fire;
    assign ram_addr        = in.data;
    assign capture         = pend[READ_LATENCY-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend <= '0;
            used <= '0;
        end else begin
            pend[0] <= in_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pend[i] <= pend[i-1];
            end
            case ({in_fire, out_fire})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_result_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (capture),
        .push_data (ram_read_data),
        .pop       (out_fire),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    a_used_bound: assert property (@(posedge clock) disable iff (!reset_n)
        used <= DEPTH_C);
    a_out_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (out.valid && !out.ack) |=> (out.valid && $stable(out.data)));

`ifdef FORMAL
    m_in_stable: assume property (@(posedge clock) disable iff (!reset_n)
        (in.valid && !in.ack) |=> (in.valid && $stable(in.data)));
    c_four_fires: cover property (@(posedge clock) disable iff (!reset_n)
        in_fire ##1 in_fire ##1 in_fire ##1 in_fire);
`endif

endmodule

// File: tb/tb_mem_read_port.sv
// Bench for mem_read_port with a RAM model returning 3*addr+1 after two edges.
// Directed scenarios check exact cycles; a monitor scoreboard checks order and values throughout.
module tb_mem_read_port;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 4;

    // clock / reset
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    data_interface #(.WIDTH(AW)) in_if ();
    data_interface #(.WIDTH(DW)) out_if ();
    logic [AW-1:0] ram_addr;
    logic          ram_read_enable;
    logic [DW-1:0] ram_read_data;

    mem_read_port #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .DEPTH        (DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in              (in_if),
        .out             (out_if),
        .ram_addr        (ram_addr),
        .ram_read_enable (ram_read_enable),
        .ram_read_data   (ram_read_data)
    );

    int checks = 0;
    int fails  = 0;
    int n_in   = 0;
    int n_out  = 0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return DW'(a) * DW'(3) + DW'(1);
    endfunction

    // RAM model; unstrobed cycles produce junk so a stray capture shows up.
    logic [DW-1:0] ram_pipe [RL];
    always @(posedge clock) begin
        ram_pipe[0] <= ram_read_enable ? ram_val(ram_addr) : DW'($urandom);
        for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_read_data = ram_pipe[RL-1];

    // scoreboard monitor, sampled mid-cycle after inputs settle
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clock) begin
        logic [DW-1:0] exp;
        #2;
        if (reset_n) begin
            if (in_if.valid && in_if.ack) begin
                exp_q.push_back(ram_val(in_if.data));
                n_in++;
            end
            if (out_if.valid && out_if.ack) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %0d, required no output", out_if.data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_if.data !== exp) begin
                        fails++;
                        $display("FAIL sb_data: got %0d, required %0d", out_if.data, exp);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_if.valid !== 1'b1 || out_if.data !== prev_data) begin
                    fails++;
                    $display("FAIL sb_hold: got valid=%b data=%0d, required 1 %0d",
                             out_if.valid, out_if.data, prev_data);
                end
            end
        end
        prev_stall = reset_n && out_if.valid && !out_if.ack;
        prev_data  = out_if.data;
    end

    task automatic drain(input string name);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            in_if.valid = 1'b0;
            out_if.ack  = 1'b1;
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0; in_if.valid = 1'b1; in_if.data = 16'h33; out_if.ack = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (in_if.ack !== 1'b0 || out_if.valid !== 1'b0 || out_if.data !== '0 || ram_read_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b valid=%b data=%0d en=%b, required 0 0 0 0",
                     in_if.ack, out_if.valid, out_if.data, ram_read_enable);
        end
        @(negedge clock);
        reset_n = 1'b1; in_if.valid = 1'b0;
        #1;
        checks++;
        if (in_if.ack !== 1'b1 || out_if.valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ack=%b valid=%b, required 1 0", in_if.ack, out_if.valid);
        end
    endtask

    task automatic test_single();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        @(negedge clock);
        in_if.valid = 1'b1; in_if.data = 16'd5; out_if.ack = 1'b1;
        #1;
        checks++;
        if (in_if.ack !== 1'b1 || ram_read_enable !== 1'b1 || ram_addr !== 16'd5) begin
            fails++;
            $display("FAIL single_issue: ack=%b en=%b addr=%0d, required 1 1 5",
                     in_if.ack, ram_read_enable, ram_addr);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            in_if.valid = 1'b0;
            #1;
            exp_v = (c == 3);
            exp_d = exp_v ? DW'(16) : '0;
            checks++;
            if (out_if.valid !== exp_v || out_if.data !== exp_d) begin
                fails++;
                $display("FAIL single_out_c%0d: valid=%b data=%0d, required %b %0d",
                         c, out_if.valid, out_if.data, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_streaming();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clock);
            in_if.valid = (c < 8); in_if.data = AW'(c); out_if.ack = 1'b1;
            #1;
            if (c < 8) begin
                checks++;
                if (in_if.ack !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ack_c%0d: ack=%b, required 1", c, in_if.ack);
                end
            end
            exp_v = (c >= 3 && c <= 10);
            exp_d = exp_v ? DW'(3 * (c - 3) + 1) : '0;
            checks++;
            if (out_if.valid !== exp_v || out_if.data !== exp_d) begin
                fails++;
                $display("FAIL stream_out_c%0d: valid=%b data=%0d, required %b %0d",
                         c, out_if.valid, out_if.data, exp_v, exp_d);
            end
        end
        drain("stream");
    endtask

    task automatic test_backpressure();
        int idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            in_if.valid = 1'b1; in_if.data = AW'(idx); out_if.ack = 1'b0;
            #1;
            if (in_if.ack) idx++;
            if (c >= 3) begin
                checks++;
                if (out_if.valid !== 1'b1 || out_if.data !== DW'(1)) begin
                    fails++;
                    $display("FAIL bp_hold_c%0d: valid=%b data=%0d, required 1 1",
                             c, out_if.valid, out_if.data);
                end
            end
        end
        checks++;
        if (idx != 4 || in_if.ack !== 1'b0) begin
            fails++;
            $display("FAIL bp_accepted: accepted=%0d ack=%b, required 4 0", idx, in_if.ack);
        end
        for (int c = 0; c < 40 && idx < 10; c++) begin
            @(negedge clock);
            in_if.valid = 1'b1; in_if.data = AW'(idx); out_if.ack = 1'b1;
            #1;
            if (in_if.ack) idx++;
        end
        checks++;
        if (idx != 10) begin
            fails++;
            $display("FAIL bp_release: accepted=%0d, required 10", idx);
        end
        drain("bp");
    endtask

    task automatic test_pop_frees_credit();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            in_if.valid = 1'b1; in_if.data = AW'(20 + c); out_if.ack = 1'b0;
        end
        repeat (4) begin
            @(negedge clock);
            in_if.valid = 1'b0;
        end
        #1;
        checks++;
        if (in_if.ack !== 1'b0 || out_if.valid !== 1'b1 || out_if.data !== DW'(61)) begin
            fails++;
            $display("FAIL credit_full: ack=%b valid=%b data=%0d, required 0 1 61",
                     in_if.ack, out_if.valid, out_if.data);
        end
        @(negedge clock);
        in_if.valid = 1'b1; in_if.data = AW'(24); out_if.ack = 1'b1;
        #1;
        checks++;
        if (in_if.ack !== 1'b1 || ram_read_enable !== 1'b1) begin
            fails++;
            $display("FAIL credit_pop_ack: ack=%b en=%b, required 1 1", in_if.ack, ram_read_enable);
        end
        @(negedge clock);
        in_if.valid = 1'b0; out_if.ack = 1'b0;
        #1;
        checks++;
        if (in_if.ack !== 1'b0 || out_if.data !== DW'(64)) begin
            fails++;
            $display("FAIL credit_still_full: ack=%b data=%0d, required 0 64", in_if.ack, out_if.data);
        end
        drain("credit");
    endtask

    task automatic test_reset_mid_stream();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            in_if.valid = 1'b1; in_if.data = AW'(2 + c); out_if.ack = 1'b1;
        end
        @(negedge clock);
        in_if.valid = 1'b0; reset_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (out_if.valid !== 1'b0 || in_if.ack !== 1'b0 || ram_read_enable !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_during: valid=%b ack=%b en=%b, required 0 0 0",
                     out_if.valid, in_if.ack, ram_read_enable);
        end
        for (int c = 3; c <= 10; c++) begin
            @(negedge clock);
            reset_n = 1'b1;
            in_if.valid = (c == 6); in_if.data = AW'(9);
            #1;
            if (c == 3) begin
                checks++;
                if (in_if.ack !== 1'b1) begin
                    fails++;
                    $display("FAIL rst_mid_ack: ack=%b, required 1", in_if.ack);
                end
            end
            exp_v = (c == 9);
            exp_d = exp_v ? DW'(28) : '0;
            checks++;
            if (out_if.valid !== exp_v || out_if.data !== exp_d) begin
                fails++;
                $display("FAIL rst_mid_out_c%0d: valid=%b data=%0d, required %b %0d",
                         c, out_if.valid, out_if.data, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_stall_random();
        int   in0  = n_in;
        int   out0 = n_out;
        logic hold = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (!hold) begin
                in_if.valid = ($urandom_range(0, 3) != 0);
                in_if.data  = AW'($urandom_range(0, 65535));
            end
            out_if.ack = ($urandom_range(0, 3) < 2);
            #1;
            hold = in_if.valid && !in_if.ack;
        end
        drain("random");
        checks++;
        if ((n_out - out0) != (n_in - in0) || (n_in - in0) < 100) begin
            fails++;
            $display("FAIL random_count: out=%0d in=%0d, required equal and >= 100",
                     n_out - out0, n_in - in0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        out_if.ack  = 1'b1;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_pop_frees_credit();
        test_reset_mid_stream();
        test_stall_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
